// File: rtl/array_ofifo.sv
// array_ofifo: per-column output FIFO behind the MAC array; lanes fill independently, pop as a row.
// Optional sticky overflow flag under `ARRAY_OFIFO_OVERFLOW_FLAG_EN`.  Revision 1.0
`default_nettype none

module array_ofifo #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int DEPTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COL-1:0]         wr,
    input  logic [COL*PSUM_BW-1:0] in,
    input  logic                   rd,
    output logic                   o_valid,
    output logic [COL*PSUM_BW-1:0] out,
    output logic                   o_full,
`ifdef ARRAY_OFIFO_OVERFLOW_FLAG_EN
    output logic                   o_overflow,
`endif
    output logic                   o_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [COL-1:0]         w_nonempty;
    logic [COL-1:0]         w_full;
    logic [COL*PSUM_BW-1:0] w_head;
    logic                   w_pop;

    // A row pops only when every lane has data, so all lanes advance together.
    assign w_pop   = rd & o_valid;
    assign o_valid = &w_nonempty;
    assign o_full  = |w_full;
    assign o_ready = ~o_full;
    assign out     = o_valid ? w_head : '0;

    genvar c;
    generate
        for (c = 0; c < COL; c++) begin : g_lane
            logic [PSUM_BW-1:0] mem_q [DEPTH];
            logic [PTR_W-1:0]   wptr_q, wptr_d;
            logic [PTR_W-1:0]   rptr_q, rptr_d;
            logic [CNT_W-1:0]   cnt_q, cnt_d;
            logic               w_acc;

            assign w_full[c]     = (cnt_q == CNT_FULL);
            assign w_nonempty[c] = (cnt_q != '0);
            // A full lane can still take a write when the same edge frees a slot.
            assign w_acc         = wr[c] & (~w_full[c] | w_pop);
            assign w_head[c*PSUM_BW +: PSUM_BW] = mem_q[rptr_q];

            always_comb begin
                wptr_d = wptr_q;
                rptr_d = rptr_q;
                cnt_d  = cnt_q;
                if (w_acc) wptr_d = wptr_q + PTR_W'(1);
                if (w_pop) rptr_d = rptr_q + PTR_W'(1);
                case ({w_acc, w_pop})
                    2'b10:   cnt_d = cnt_q + CNT_W'(1);
                    2'b01:   cnt_d = cnt_q - CNT_W'(1);
                    default: cnt_d = cnt_q;
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wptr_q <= '0;
                    rptr_q <= '0;
                    cnt_q  <= '0;
                end else begin
                    wptr_q <= wptr_d;
                    rptr_q <= rptr_d;
                    cnt_q  <= cnt_d;
                end
            end

            always_ff @(posedge clk) begin
                if (!reset && w_acc) mem_q[wptr_q] <= in[c*PSUM_BW +: PSUM_BW];
            end
        end
    endgenerate

`ifdef ARRAY_OFIFO_OVERFLOW_FLAG_EN
    logic [COL-1:0] w_drop;
    logic           overflow_q;

    assign w_drop     = wr & w_full & {COL{~w_pop}};
    assign o_overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (reset) overflow_q <= 1'b0;
        else       overflow_q <= overflow_q | (|w_drop);
    end
`endif

endmodule

`default_nettype wire
